// File: rtl/shift_seq32.sv
// shift_seq32 - multi-cycle shift unit for the ALU shifter path.
//
// Accepts a shift request in IDLE, then moves the work register one bit per
// clock until the requested distance is covered. The result is registered
// into out on the same edge that enters DONE, and done pulses for one cycle.
//
// Ports:
//   clk       system clock, rising-edge
//   rst       synchronous active-high reset
//   start     request strobe, only looked at in IDLE
//   in        operand, sampled with start
//   amount    shift distance 0..WIDTH-1, sampled with start
//   shiftdir  1 = left, 0 = right, sampled with start
//   arith     1 = sign-filling right shift (ignored for left shifts)
//   out       result of the last completed operation (held between ops)
//   busy      high in SHIFT and DONE
//   done      one-cycle pulse, out is updated in this cycle
//
// WIDTH must equal 2**AMTW so every legal amount fits the counter.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; operands are latched on the accept edge
// S_SHIFT | one-bit shift per cycle, counter counts down to 1
// S_DONE  | out holds the new result, done=1, back to IDLE next cycle

module shift_seq32 #(
  parameter int WIDTH = 32,
  parameter int AMTW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMTW-1:0]  amount,
  input  logic             shiftdir,
  input  logic             arith,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AMTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  always_comb begin
    // Right shift fills the vacated MSB with the old MSB only when arith is set.
    if (dir_q) begin
      shifted = {work_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    dir_d   = dir_q;
    arith_d = arith_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = in;
          cnt_d   = amount;
          dir_d   = shiftdir;
          arith_d = arith;
          if (amount == '0) begin
            // Zero-distance request: result is the operand itself.
            out_d   = in;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - AMTW'(1);
        if (cnt_q == AMTW'(1)) begin
          out_d   = shifted;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out  = out_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_seq32.sv
module tb_shift_seq32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] d_in;
  logic [4:0]  d_amount;
  logic        d_dir;
  logic        d_arith;
  logic [31:0] d_out;
  logic        d_busy;
  logic        d_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_seq32 #(.WIDTH(32), .AMTW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in       (d_in),
    .amount   (d_amount),
    .shiftdir (d_dir),
    .arith    (d_arith),
    .out      (d_out),
    .busy     (d_busy),
    .done     (d_done)
  );

  typedef struct {
    logic [31:0] v_in;
    logic [4:0]  v_amt;
    logic        v_dir;
    logic        v_ar;
    logic [31:0] v_exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain shift operators on the whole word.
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int a,
                                            input logic dir, input logic ar);
    if (dir) return v << a;
    if (ar)  return 32'($signed(v) >>> a);
    return v >> a;
  endfunction

  // Launch one request and wait for its done pulse. Latency is counted in
  // negedge samples after the accepting edge (1 = visible right after it).
  task automatic run_op(input logic [31:0] i_in, input logic [4:0] i_amt,
                        input logic i_dir, input logic i_ar,
                        output logic [31:0] r_out, output int r_lat);
    logic [31:0] prev;
    bit held;
    bit busy_ok;
    @(negedge clk);
    d_in = i_in; d_amount = i_amt; d_dir = i_dir; d_arith = i_ar; start = 1'b1;
    prev = d_out;
    @(posedge clk);
    #1;
    start = 1'b0;
    d_in = $urandom; d_amount = 5'($urandom); d_dir = 1'($urandom); d_arith = 1'($urandom);
    r_lat = 0; held = 1; busy_ok = 1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!d_busy) busy_ok = 0;
      if (d_done) begin
        r_lat = n;
        break;
      end
      if (d_out !== prev) held = 0;
    end
    r_out = d_out;
    check("out_held_mid_shift", 32'(held), 32'd1);
    check("busy_during_op", 32'(busy_ok), 32'd1);
    @(negedge clk);
    check("idle_after_done", {30'd0, d_busy, d_done}, 32'd0);
  endtask

  vec_t vecs[8];
  logic [31:0] r;
  int lat;
  int pulses;
  int pulse_at;

  initial begin
    vecs[0] = '{32'h0000_0002, 5'd1,  1'b1, 1'b0, 32'h0000_0004};
    vecs[1] = '{32'h0000_0002, 5'd1,  1'b0, 1'b0, 32'h0000_0001};
    vecs[2] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001};
    vecs[5] = '{32'h0000_0001, 5'd31, 1'b1, 1'b1, 32'h8000_0000};
    vecs[6] = '{32'hF000_000F, 5'd4,  1'b0, 1'b1, 32'hFF00_0000};
    vecs[7] = '{32'h8000_0001, 5'd3,  1'b1, 1'b1, 32'h0000_0008};

    rst = 1'b1; start = 1'b0; d_in = '0; d_amount = '0; d_dir = 1'b0; d_arith = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", d_out, 32'h0);
    check("reset_busy_done", {30'd0, d_busy, d_done}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].v_in, vecs[i].v_amt, vecs[i].v_dir, vecs[i].v_ar, r, lat);
      check($sformatf("vec%0d_out", i), r, vecs[i].v_exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].v_amt) + 32'd1);
    end

    for (int t = 0; t < 40; t++) begin
      logic [31:0] v;
      logic [4:0]  a;
      logic        dr, ar;
      v  = $urandom;
      a  = 5'($urandom_range(0, 31));
      dr = 1'($urandom);
      ar = 1'($urandom);
      run_op(v, a, dr, ar, r, lat);
      check($sformatf("rand%0d_out", t), r, ref_shift(v, int'(a), dr, ar));
      check($sformatf("rand%0d_latency", t), 32'(lat), 32'(a) + 32'd1);
    end

    // Start while busy must be ignored.
    @(negedge clk);
    d_in = 32'h1; d_amount = 5'd4; d_dir = 1'b1; d_arith = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0; pulse_at = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 2) begin
        d_in = 32'hFFFF_FFFF; d_amount = 5'd1; d_dir = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (d_done) begin
        pulses++;
        if (pulse_at == 0) begin
          pulse_at = n;
          check("busy_start_out", d_out, 32'h0000_0010);
        end
      end
    end
    check("busy_start_pulses", 32'(pulses), 32'd1);
    check("busy_start_latency", 32'(pulse_at), 32'd5);

    // Reset mid-operation discards the shift.
    @(negedge clk);
    d_in = 32'h0000_0003; d_amount = 5'd20; d_dir = 1'b1; d_arith = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy_done", {30'd0, d_busy, d_done}, 32'd0);
    check("rst_mid_out", d_out, 32'h0);
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (d_done || d_busy) pulses++;
    end
    check("rst_mid_no_late_done", 32'(pulses), 32'd0);
    run_op(32'h0000_0003, 5'd20, 1'b1, 1'b0, r, lat);
    check("after_rst_out", r, 32'h0030_0000);
    check("after_rst_latency", 32'(lat), 32'd21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
